// File: rtl/vga_square_animator_if.sv
// Pixel-side bundle between the board top level and the square animator.
// Latency: none, plain wires; outputs are registered inside the animator.
// Backpressure: none; in_strobe paces everything, the sink must keep up.
interface vga_square_animator_if #(
    parameter int COLOR_BITS = 4
);
    logic                  in_strobe;
    logic                  in_enable;
    logic                  out_hsync;
    logic                  out_vsync;
    logic [COLOR_BITS-1:0] out_red;
    logic [COLOR_BITS-1:0] out_green;
    logic [COLOR_BITS-1:0] out_blue;
    logic [9:0]            out_x;
    logic [9:0]            out_y;
    logic                  out_frame;

    // Board top level: supplies strobe/enable, consumes the video stream.
    modport master (
        output in_strobe,
        output in_enable,
        input  out_hsync,
        input  out_vsync,
        input  out_red,
        input  out_green,
        input  out_blue,
        input  out_x,
        input  out_y,
        input  out_frame
    );

    // Animator side.
    modport slave (
        input  in_strobe,
        input  in_enable,
        output out_hsync,
        output out_vsync,
        output out_red,
        output out_green,
        output out_blue,
        output out_x,
        output out_y,
        output out_frame
    );
endinterface

// File: rtl/vga_square_animator.sv
// VGA timing source that composites N_SQ solid squares bouncing inside the active area.
// Latency: one in_strobe from counter state to registered sync/colour/x/y/frame outputs.
// Backpressure: none; all state advances only on in_strobe and holds between strobes.
module vga_square_animator #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int N_SQ       = 4,
    parameter int SQ_SIZE    = 160,
    parameter int SPEED      = 1,
    parameter int COLOR_BITS = 4,
    // Start position of square k is (SQ_X0 + SQ_STEP*k, SQ_Y0 + SQ_STEP*k).
    parameter int SQ_X0      = 120,
    parameter int SQ_Y0      = 40,
    parameter int SQ_STEP    = 80
) (
    input  logic                    in_clock,
    input  logic                    in_reset_n,
    vga_square_animator_if.slave    bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] SQ_W    = 11'(SQ_SIZE);
    localparam logic [11:0] SQ_W12  = 12'(SQ_SIZE);
    localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM   = 12'(V_ACTIVE);
    localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - SQ_SIZE);
    localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - SQ_SIZE);
    localparam logic signed [10:0] STEP_S = 11'(SPEED);

    // Raster counters
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Square state: origin and direction (neg = moving towards 0)
    logic [N_SQ-1:0][9:0] px_q, px_d;
    logic [N_SQ-1:0][9:0] py_q, py_d;
    logic [N_SQ-1:0]      dx_neg_q, dx_neg_d;
    logic [N_SQ-1:0]      dy_neg_q, dy_neg_d;

    // Registered outputs
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic [COLOR_BITS-1:0] red_q, red_d;
    logic [COLOR_BITS-1:0] green_q, green_d;
    logic [COLOR_BITS-1:0] blue_q, blue_d;
    logic [9:0]            x_q, x_d;
    logic [9:0]            y_q, y_d;
    logic                  frame_q, frame_d;

    // Combinational helpers
    logic                  frame_end;
    logic                  active;
    logic                  hit;
    logic [1:0]            hit_idx;
    logic [10:0]           h_ext;
    logic [10:0]           v_ext;
    logic signed [10:0]    nxt_x;
    logic signed [10:0]    nxt_y;

    assign h_ext     = {1'b0, h_cnt_q};
    assign v_ext     = {1'b0, v_cnt_q};
    assign frame_end = bus.in_strobe && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    // Raster counters: h wraps at line end and carries into v.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (bus.in_strobe) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Hit test; scanning from the top index down lets the lowest index win overlaps.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int k = N_SQ - 1; k >= 0; k--) begin
            if ((h_ext >= {1'b0, px_q[k]}) && (h_ext < {1'b0, px_q[k]} + SQ_W) &&
                (v_ext >= {1'b0, py_q[k]}) && (v_ext < {1'b0, py_q[k]} + SQ_W)) begin
                hit     = 1'b1;
                hit_idx = 2'(k);
            end
        end
    end

    // Per-frame motion: step each axis, clamp to the edge and reverse on overflow.
    always_comb begin
        px_d     = px_q;
        py_d     = py_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        nxt_x    = '0;
        nxt_y    = '0;
        if (frame_end && bus.in_enable) begin
            for (int k = 0; k < N_SQ; k++) begin
                nxt_x = $signed({1'b0, px_q[k]}) + (dx_neg_q[k] ? -STEP_S : STEP_S);
                if (nxt_x[10]) begin
                    px_d[k]     = '0;
                    dx_neg_d[k] = ~dx_neg_q[k];
                end else if ({1'b0, nxt_x} + SQ_W12 > H_LIM) begin
                    px_d[k]     = X_MAX;
                    dx_neg_d[k] = ~dx_neg_q[k];
                end else begin
                    px_d[k]     = nxt_x[9:0];
                end

                nxt_y = $signed({1'b0, py_q[k]}) + (dy_neg_q[k] ? -STEP_S : STEP_S);
                if (nxt_y[10]) begin
                    py_d[k]     = '0;
                    dy_neg_d[k] = ~dy_neg_q[k];
                end else if ({1'b0, nxt_y} + SQ_W12 > V_LIM) begin
                    py_d[k]     = Y_MAX;
                    dy_neg_d[k] = ~dy_neg_q[k];
                end else begin
                    py_d[k]     = nxt_y[9:0];
                end
            end
        end
    end

    // Output stage: sync, colour, coordinates and frame flag all from the same counter values.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (bus.in_strobe) begin
            hsync_d = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
            vsync_d = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
            if (active && hit) begin
                case (hit_idx)
                    2'd1:    red_d   = {COLOR_BITS{1'b1}};
                    2'd2:    blue_d  = {COLOR_BITS{1'b1}};
                    default: green_d = {COLOR_BITS{1'b1}};
                endcase
            end
            x_d     = h_cnt_q;
            y_d     = v_cnt_q;
            frame_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        end
    end

    // State register; asynchronous reset overrides any concurrent strobe.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            for (int k = 0; k < N_SQ; k++) begin
                px_q[k] <= 10'(SQ_X0 + SQ_STEP * k);
                py_q[k] <= 10'(SQ_Y0 + SQ_STEP * k);
            end
            dx_neg_q <= '0;
            dy_neg_q <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            frame_q  <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            px_q     <= px_d;
            py_q     <= py_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            x_q      <= x_d;
            y_q      <= y_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.out_hsync = hsync_q;
    assign bus.out_vsync = vsync_q;
    assign bus.out_red   = red_q;
    assign bus.out_green = green_q;
    assign bus.out_blue  = blue_q;
    assign bus.out_x     = x_q;
    assign bus.out_y     = y_q;
    assign bus.out_frame = frame_q;

endmodule

// File: tb/tb_vga_square_animator.sv
// Bench for vga_square_animator on a scaled-down raster (80x55 total, 64x48 active, 16-pixel squares).
// Latency: expected records are queued when a strobe is driven and compared one strobe later.
// Backpressure: not applicable; the bench paces the DUT with in_strobe.
module tb_vga_square_animator;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;  // 80
    localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;  // 55
    localparam int FRAME = HT * VT;                                          // 4400

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_square_animator_if #(.COLOR_BITS(4)) bus();

    vga_square_animator #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .N_SQ(4), .SQ_SIZE(16), .SPEED(1), .COLOR_BITS(4),
        .SQ_X0(12), .SQ_Y0(4), .SQ_STEP(8)
    ) dut (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .bus        (bus)
    );

    // Pixel probe: colour expected at (x,y) during a given frame phase.
    typedef struct {
        int         phase;
        int         x;
        int         y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } probe_t;

    // Expected output record pushed when a strobe is driven.
    typedef struct {
        int         x;
        int         y;
        logic       hs;
        logic       vs;
        logic       fr;
        logic       chk_col;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } exp_t;

    probe_t probes[$];
    exp_t   sb[$];
    exp_t   last_exp;

    int errors = 0;
    int checks = 0;
    int hm = 0, vm = 0, phase = 0;
    int strobe_idx = 0;
    int last_frame_idx = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add_probe(input int ph, input int x, input int y,
                                      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        probe_t p;
        p.phase = ph; p.x = x; p.y = y; p.r = r; p.g = g; p.b = b;
        probes.push_back(p);
    endfunction

    function automatic exp_t make_exp(input int h, input int v, input int ph);
        exp_t e;
        e.x       = h;
        e.y       = v;
        e.hs      = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
        e.vs      = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
        e.fr      = (h == 0 && v == 0);
        e.chk_col = 1'b0;
        e.r = '0; e.g = '0; e.b = '0;
        if (!(h < HA && v < VA)) begin
            e.chk_col = 1'b1;
        end else begin
            foreach (probes[i]) begin
                if (probes[i].phase == ph && probes[i].x == h && probes[i].y == v) begin
                    e.chk_col = 1'b1;
                    e.r = probes[i].r; e.g = probes[i].g; e.b = probes[i].b;
                end
            end
        end
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_hsync"}, bus.out_hsync, 1'b1);
        chk({tag, "_vsync"}, bus.out_vsync, 1'b1);
        chk({tag, "_red"},   bus.out_red,   4'h0);
        chk({tag, "_green"}, bus.out_green, 4'h0);
        chk({tag, "_blue"},  bus.out_blue,  4'h0);
        chk({tag, "_x"},     bus.out_x,     10'd0);
        chk({tag, "_y"},     bus.out_y,     10'd0);
        chk({tag, "_frame"}, bus.out_frame, 1'b0);
    endtask

    task automatic compare_out();
        exp_t e;
        string at;
        e  = sb.pop_front();
        at = $sformatf("@(%0d,%0d)p%0d", e.x, e.y, phase);
        chk({"hsync", at}, bus.out_hsync, e.hs);
        chk({"vsync", at}, bus.out_vsync, e.vs);
        chk({"frame", at}, bus.out_frame, e.fr);
        chk({"x", at},     bus.out_x,     e.x);
        chk({"y", at},     bus.out_y,     e.y);
        if (e.chk_col) begin
            chk({"red", at},   bus.out_red,   e.r);
            chk({"green", at}, bus.out_green, e.g);
            chk({"blue", at},  bus.out_blue,  e.b);
        end
        if (bus.out_frame === 1'b1) begin
            if (last_frame_idx >= 0)
                chk("frame_period", strobe_idx - last_frame_idx, FRAME);
            last_frame_idx = strobe_idx;
        end
        last_exp = e;
    endtask

    // One strobe: queue the expectation for the current raster position, then compare.
    task automatic strobe_once(input int gap);
        @(negedge clk);
        bus.in_strobe = 1'b1;
        sb.push_back(make_exp(hm, vm, phase));
        @(posedge clk);
        #1;
        bus.in_strobe = 1'b0;
        compare_out();
        strobe_idx++;
        hm++;
        if (hm == HT) begin
            hm = 0;
            vm++;
            if (vm == VT) vm = 0;
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic sweep(input int n, input int gap, input int stall_idx,
                         input int en_on_idx, input int en_off_idx);
        for (int i = 0; i < n; i++) begin
            if (i == en_on_idx)  bus.in_enable = 1'b1;
            if (i == en_off_idx) bus.in_enable = 1'b0;
            if (i == stall_idx) begin
                repeat (1000) @(posedge clk);
                #1;
                chk("stall_hsync", bus.out_hsync, last_exp.hs);
                chk("stall_vsync", bus.out_vsync, last_exp.vs);
                chk("stall_x",     bus.out_x,     last_exp.x);
                chk("stall_y",     bus.out_y,     last_exp.y);
                chk("stall_red",   bus.out_red,   last_exp.r);
                chk("stall_green", bus.out_green, last_exp.g);
                chk("stall_blue",  bus.out_blue,  last_exp.b);
            end
            strobe_once(gap);
        end
    endtask

    initial begin
        // Phase 0/1: reset positions sq0 (12,4) sq1 (20,12) sq2 (28,20) sq3 (36,28)
        add_probe(0, 12,  4, 4'h0, 4'hF, 4'h0);
        add_probe(0, 11,  4, 4'h0, 4'h0, 4'h0);
        add_probe(0, 20, 12, 4'h0, 4'hF, 4'h0);
        add_probe(0, 34, 12, 4'hF, 4'h0, 4'h0);
        add_probe(0, 30, 22, 4'hF, 4'h0, 4'h0);
        add_probe(0, 28, 20, 4'hF, 4'h0, 4'h0);
        add_probe(0, 40, 30, 4'h0, 4'h0, 4'hF);
        add_probe(0, 39, 20, 4'h0, 4'h0, 4'hF);
        add_probe(0, 45, 40, 4'h0, 4'hF, 4'h0);
        add_probe(0, 27, 19, 4'h0, 4'hF, 4'h0);
        add_probe(0, 28,  4, 4'h0, 4'h0, 4'h0);
        add_probe(1, 12,  4, 4'h0, 4'hF, 4'h0);
        add_probe(1, 11,  4, 4'h0, 4'h0, 4'h0);
        // Phase 2: one step, sq0 at (13,5)
        add_probe(2, 12,  4, 4'h0, 4'h0, 4'h0);
        add_probe(2, 13,  5, 4'h0, 4'hF, 4'h0);
        add_probe(2, 28, 20, 4'h0, 4'hF, 4'h0);
        // Phase 6: five steps, sq3 at (41,32) after its y bounce
        add_probe(6, 40, 45, 4'h0, 4'h0, 4'h0);
        add_probe(6, 41, 45, 4'h0, 4'hF, 4'h0);
        add_probe(6, 50, 31, 4'h0, 4'h0, 4'h0);
        add_probe(6, 50, 32, 4'h0, 4'hF, 4'h0);
        add_probe(6, 50, 47, 4'h0, 4'hF, 4'h0);
        // Phase 7: six steps, sq3 at (42,31) moving up
        add_probe(7, 41, 45, 4'h0, 4'h0, 4'h0);
        add_probe(7, 42, 45, 4'h0, 4'hF, 4'h0);
        add_probe(7, 50, 31, 4'h0, 4'hF, 4'h0);
        add_probe(7, 50, 47, 4'h0, 4'h0, 4'h0);
        // Phase 8: seven steps, sq2 at (35,27)
        add_probe(8, 45, 40, 4'h0, 4'h0, 4'hF);
        // Phase 9: after mid-frame reset, positions back to start
        add_probe(9, 12,  4, 4'h0, 4'hF, 4'h0);
        add_probe(9, 11,  4, 4'h0, 4'h0, 4'h0);

        // Reset held with strobe high: reset must win.
        bus.in_strobe = 1'b1;
        bus.in_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        bus.in_strobe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Frozen frame at half strobe rate, with a stall and a mid-frame enable pulse.
        phase = 0;
        sweep(FRAME, 1, 20 * HT + 40, 2000, 3000);

        // Animated frames at full strobe rate.
        bus.in_enable = 1'b1;
        for (int p = 1; p <= 7; p++) begin
            phase = p;
            sweep(FRAME, 0, -1, -1, -1);
        end
        phase = 8;
        sweep(40 * HT + 46, 0, -1, -1, -1);

        // Asynchronous reset mid-line, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        hm = 0;
        vm = 0;
        last_frame_idx = -1;
        phase = 9;
        sweep(5 * HT + 13, 0, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
